// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the mm:ss BCD stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} sw_state_t;

    localparam int SEC_ONES_MAX = 9;
    localparam int SEC_TENS_MAX = 5;
    localparam int MIN_ONES_MAX = 9;
    localparam int MIN_TENS_MAX = 5;

    // Packed time layout, LSB first: sec_ones[3:0], sec_tens[6:4], min_ones[10:7], min_tens[13:11]
    localparam int TIME_W = 14;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit counting 0..MAX; co flags the enabled rollover that carries into the next digit.
module bcd_digit #(
    parameter int MAX = 9,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         co
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = (q_q == MAX_V) ? '0 : q_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign co = en && (q_q == MAX_V);

endmodule

// File: rtl/bcd_stopwatch.sv
// mm:ss BCD stopwatch with run/pause/clear FSM, tick prescaler and 59:59 wrap pulse.
// Define STOPWATCH_LAP_EN to add the lap input and the frozen-snapshot display.
module bcd_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
`ifdef STOPWATCH_LAP_EN
    input  logic       lap,
`endif
    output logic [3:0] sec_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [2:0] min_tens,
    output logic       running,
    output logic       wrap
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    sw_state_t         state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              wrap_q, wrap_d;
    logic              tick_ok;
    logic              sec_en;
    logic [3:0]        dig_en, dig_co;
    logic [TIME_W-1:0] dig_time;
    logic [TIME_W-1:0] disp;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!clear && start) state_d = RUN;
            RUN:     if (clear) state_d = IDLE; else if (stop) state_d = PAUSE;
            PAUSE:   if (clear) state_d = IDLE; else if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Tick is qualified by the registered state, so a start edge's own tick is dropped.
    always_comb begin
        tick_ok = tick && (state_q == RUN) && !clear;
        div_d   = div_q;
        sec_en  = 1'b0;
        if (clear) begin
            div_d = '0;
        end else if (tick_ok) begin
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                sec_en = 1'b1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    assign dig_en = {dig_co[2:0], sec_en};
    assign wrap_d = dig_co[3];

    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        localparam int DMAX = (gi == 0) ? SEC_ONES_MAX :
                              (gi == 1) ? SEC_TENS_MAX :
                              (gi == 2) ? MIN_ONES_MAX : MIN_TENS_MAX;
        localparam int DW   = $clog2(DMAX + 1);
        localparam int OFF  = (gi == 0) ? 0 : (gi == 1) ? 4 : (gi == 2) ? 7 : 11;
        logic [DW-1:0] q;

        bcd_digit #(.MAX(DMAX), .W(DW)) u_digit (
            .clk (clk),
            .rst (rst),
            .clr (clear),
            .en  (dig_en[gi]),
            .q   (q),
            .co  (dig_co[gi])
        );
        assign dig_time[OFF +: DW] = q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            wrap_q  <= wrap_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic              lap_hold_q, lap_hold_d;
    logic [TIME_W-1:0] lap_q, lap_d;

    // A lap while holding always releases, even outside RUN.
    always_comb begin
        lap_hold_d = lap_hold_q;
        lap_d      = lap_q;
        if (clear) begin
            lap_hold_d = 1'b0;
        end else if (lap && lap_hold_q) begin
            lap_hold_d = 1'b0;
        end else if (lap && (state_q == RUN)) begin
            lap_hold_d = 1'b1;
            lap_d      = dig_time;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lap_hold_q <= 1'b0;
            lap_q      <= '0;
        end else begin
            lap_hold_q <= lap_hold_d;
            lap_q      <= lap_d;
        end
    end

    assign disp = lap_hold_q ? lap_q : dig_time;
`else
    assign disp = dig_time;
`endif

    assign sec_ones = disp[3:0];
    assign sec_tens = disp[6:4];
    assign min_ones = disp[10:7];
    assign min_tens = disp[13:11];
    assign running  = (state_q == RUN);
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Self-checking bench for bcd_stopwatch: vector table, corner sequences and randomized run vs a seconds-based model.
module tb_bcd_stopwatch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, tick = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;
    logic [3:0] so, mo;
    logic [2:0] st, mt;
    logic running, wrap;

    logic tick2 = 1'b0, start2 = 1'b0;
    logic [3:0] so2, mo2;
    logic [2:0] st2, mt2;
    logic running2, wrap2;

    bcd_stopwatch #(.TICK_DIV(1)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .clear(clear),
`ifdef STOPWATCH_LAP_EN
        .lap(lap),
`endif
        .sec_ones(so), .sec_tens(st), .min_ones(mo), .min_tens(mt),
        .running(running), .wrap(wrap)
    );

    bcd_stopwatch #(.TICK_DIV(20)) dut20 (
        .clk(clk), .rst(rst), .tick(tick2), .start(start2), .stop(1'b0), .clear(1'b0),
`ifdef STOPWATCH_LAP_EN
        .lap(1'b0),
`endif
        .sec_ones(so2), .sec_tens(st2), .min_ones(mo2), .min_tens(mt2),
        .running(running2), .wrap(wrap2)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: elapsed time held as plain seconds 0..3599
    int m_state = 0;   // 0 idle, 1 run, 2 pause
    int m_secs = 0, m_div = 0, m_lap = 0;
    bit m_hold = 0, m_wrap = 0;
    localparam int TD = 1;

    function automatic logic [13:0] digs(input int s);
        return {3'(s / 600), 4'((s / 60) % 10), 3'((s % 60) / 10), 4'(s % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic s, input logic p, input logic c, input logic t, input logic l);
        bit q;
        if (rst) begin
            m_state = 0; m_secs = 0; m_div = 0; m_lap = 0; m_hold = 0; m_wrap = 0;
            return;
        end
        q = t && (m_state == 1) && !c;
        m_wrap = 0;
        if (c) m_hold = 0;
        else if (l && m_hold) m_hold = 0;
        else if (l && m_state == 1) begin m_hold = 1; m_lap = m_secs; end
        if (c) begin
            m_secs = 0; m_div = 0;
        end else if (q) begin
            if (m_div == TD - 1) begin
                m_div = 0;
                m_secs = m_secs + 1;
                if (m_secs == 3600) begin m_secs = 0; m_wrap = 1; end
            end else begin
                m_div = m_div + 1;
            end
        end
        case (m_state)
            0: if (!c && s) m_state = 1;
            1: if (c) m_state = 0; else if (p) m_state = 2;
            default: if (c) m_state = 0; else if (s) m_state = 1;
        endcase
    endtask

    task automatic cycle(input logic s, input logic p, input logic c, input logic t);
        start = s; stop = p; clear = c; tick = t;
        @(posedge clk); #1;
        model_step(s, p, c, t, lap);
        chk("model_time", {18'd0, mt, mo, st, so}, {18'd0, digs(m_hold ? m_lap : m_secs)});
        chk("model_running", {31'd0, running}, {31'd0, m_state == 1});
        chk("model_wrap", {31'd0, wrap}, {31'd0, m_wrap});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 1);
    endtask

    task automatic restart();
        cycle(0, 0, 1, 0);
        cycle(1, 0, 0, 0);
    endtask

    typedef struct {
        logic s, p, c, t;
        int   secs;
        logic run;
    } vec_t;
    vec_t vecs[17];

    initial begin
        #5_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1, 0, 0, 0, 0, 1};
        vecs[1]  = '{0, 0, 0, 1, 1, 1};
        vecs[2]  = '{0, 0, 0, 1, 2, 1};
        vecs[3]  = '{0, 1, 0, 1, 3, 0};
        vecs[4]  = '{0, 0, 0, 1, 3, 0};
        vecs[5]  = '{1, 0, 0, 1, 3, 1};
        vecs[6]  = '{0, 0, 0, 1, 4, 1};
        vecs[7]  = '{1, 1, 0, 0, 4, 0};
        vecs[8]  = '{0, 0, 0, 1, 4, 0};
        vecs[9]  = '{0, 0, 1, 0, 0, 0};
        vecs[10] = '{0, 0, 0, 1, 0, 0};
        vecs[11] = '{0, 1, 0, 0, 0, 0};
        vecs[12] = '{1, 0, 0, 0, 0, 1};
        vecs[13] = '{0, 0, 0, 1, 1, 1};
        vecs[14] = '{1, 0, 1, 1, 0, 0};
        vecs[15] = '{1, 0, 0, 0, 0, 1};
        vecs[16] = '{0, 0, 0, 1, 1, 1};

        // Reset held two cycles with tick and start active
        rst = 1'b1;
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);
        chk("reset_time", {18'd0, mt, mo, st, so}, 32'd0);
        chk("reset_running", {31'd0, running}, 32'd0);
        chk("reset_wrap", {31'd0, wrap}, 32'd0);
        rst = 1'b0;
        $display("reset done time=%0d%0d:%0d%0d running=%0b", mt, mo, st, so, running);

        for (int i = 0; i < 17; i++) begin
            cycle(vecs[i].s, vecs[i].p, vecs[i].c, vecs[i].t);
            chk("vec_time", {18'd0, mt, mo, st, so}, {18'd0, digs(vecs[i].secs)});
            chk("vec_running", {31'd0, running}, {31'd0, vecs[i].run});
            chk("vec_wrap", {31'd0, wrap}, 32'd0);
            $display("vec %0d start=%0b stop=%0b clear=%0b tick=%0b -> %0d%0d:%0d%0d running=%0b",
                     i, vecs[i].s, vecs[i].p, vecs[i].c, vecs[i].t, mt, mo, st, so, running);
        end

        restart();
        ticks(75);
        chk("count_75", {18'd0, mt, mo, st, so}, {18'd0, 3'd0, 4'd1, 3'd1, 4'd5});
        chk("count_running", {31'd0, running}, 32'd1);
        $display("count 75 ticks -> %0d%0d:%0d%0d", mt, mo, st, so);

        restart();
        ticks(10);
        cycle(0, 1, 0, 0);
        ticks(5);
        chk("pause_hold", {18'd0, mt, mo, st, so}, {18'd0, 3'd0, 4'd0, 3'd1, 4'd0});
        chk("pause_running", {31'd0, running}, 32'd0);
        cycle(1, 0, 0, 1);
        chk("start_tick_dropped", {18'd0, mt, mo, st, so}, {18'd0, 3'd0, 4'd0, 3'd1, 4'd0});
        ticks(1);
        chk("resume_tick", {18'd0, mt, mo, st, so}, {18'd0, 3'd0, 4'd0, 3'd1, 4'd1});
        $display("pause/resume -> %0d%0d:%0d%0d", mt, mo, st, so);

        restart();
        ticks(150);
        chk("at_0230", {18'd0, mt, mo, st, so}, {18'd0, 3'd0, 4'd2, 3'd3, 4'd0});
        cycle(0, 1, 1, 1);
        chk("clear_time", {18'd0, mt, mo, st, so}, 32'd0);
        chk("clear_running", {31'd0, running}, 32'd0);
        ticks(1);
        chk("idle_tick_ignored", {18'd0, mt, mo, st, so}, 32'd0);
        $display("clear at 02:30 -> %0d%0d:%0d%0d running=%0b", mt, mo, st, so, running);

`ifdef STOPWATCH_LAP_EN
        restart();
        ticks(5);
        lap = 1'b1;
        cycle(0, 0, 0, 0);
        lap = 1'b0;
        ticks(10);
        chk("lap_frozen", {18'd0, mt, mo, st, so}, {18'd0, 3'd0, 4'd0, 3'd0, 4'd5});
        lap = 1'b1;
        cycle(0, 0, 0, 0);
        lap = 1'b0;
        chk("lap_release", {18'd0, mt, mo, st, so}, {18'd0, 3'd0, 4'd0, 3'd1, 4'd5});
        $display("lap release -> %0d%0d:%0d%0d", mt, mo, st, so);
`endif

        restart();
        ticks(3599);
        chk("at_5959", {18'd0, mt, mo, st, so}, {18'd0, 3'd5, 4'd9, 3'd5, 4'd9});
        chk("no_wrap_5959", {31'd0, wrap}, 32'd0);
        ticks(1);
        chk("wrap_time", {18'd0, mt, mo, st, so}, 32'd0);
        chk("wrap_pulse", {31'd0, wrap}, 32'd1);
        ticks(1);
        chk("wrap_one_clk", {31'd0, wrap}, 32'd0);
        chk("after_wrap", {18'd0, mt, mo, st, so}, {18'd0, 3'd0, 4'd0, 3'd0, 4'd1});
        $display("wrap 59:59 -> 00:00 -> %0d%0d:%0d%0d", mt, mo, st, so);

        // Divide-by-20 instance fed by a mod-20 terminal-count pulse
        start2 = 1'b1;
        cycle(0, 0, 0, 0);
        start2 = 1'b0;
        chk("div20_running", {31'd0, running2}, 32'd1);
        for (int k = 0; k < 1200; k++) begin
            tick2 = (k % 20 == 19);
            cycle(0, 0, 0, 0);
            if (k == 398) chk("div20_before", {28'd0, so2}, 32'd0);
            if (k == 399) chk("div20_1", {28'd0, so2}, 32'd1);
            if (k == 799) chk("div20_2", {28'd0, so2}, 32'd2);
            if (k == 1199) chk("div20_3", {28'd0, so2}, 32'd3);
        end
        tick2 = 1'b0;
        $display("div20 after 1200 clk -> sec_ones=%0d", so2);

        for (int i = 0; i < 3000; i++) begin
            logic s, p, c, t;
            s = ($urandom_range(0, 99) < 10);
            p = ($urandom_range(0, 99) < 6);
            c = ($urandom_range(0, 99) < 2);
            t = ($urandom_range(0, 99) < 75);
            if (s && p && m_state != 1) p = 1'b0;
            rst = ($urandom_range(0, 199) == 0);
`ifdef STOPWATCH_LAP_EN
            lap = ($urandom_range(0, 99) < 4);
`endif
            cycle(s, p, c, t);
            rst = 1'b0;
            lap = 1'b0;
        end
        $display("random 3000 cycles done time=%0d%0d:%0d%0d", mt, mo, st, so);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
